// File: rtl/fifo_byte_packer.sv
// Packs PACK_RATIO consecutive FIFO entries into one wide word and presents it on a
// valid/ready port with a lane-keep mask. A flush request forces out a partial word.
module fifo_byte_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int PACK_RATIO = 4,
  localparam int OUT_WIDTH = IN_WIDTH * PACK_RATIO
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_rd_en,
  input  logic [IN_WIDTH-1:0]   fifo_rd_data,
  input  logic                  fifo_rd_val,
  input  logic                  flush,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [PACK_RATIO-1:0] out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(PACK_RATIO + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PACK_RATIO);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SUM_W-1:0] SUM_LIMIT = SUM_W'(PACK_RATIO);

  function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [CNT_W-1:0] lanes);
    logic [PACK_RATIO-1:0] m;
    m = {PACK_RATIO{1'b0}};
    for (int k = 0; k < PACK_RATIO; k++) begin
      m[k] = (CNT_W'(k) < lanes);
    end
    return m;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] mask_lanes(input logic [OUT_WIDTH-1:0] word,
                                                      input logic [PACK_RATIO-1:0] keep);
    logic [OUT_WIDTH-1:0] res;
    res = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < PACK_RATIO; k++) begin
      res[k*IN_WIDTH +: IN_WIDTH] = keep[k] ? word[k*IN_WIDTH +: IN_WIDTH] : {IN_WIDTH{1'b0}};
    end
    return res;
  endfunction

  logic [OUT_WIDTH-1:0]  acc_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  pend_r;
  logic                  flush_req_r;
  logic                  rd_en_r;
  logic [OUT_WIDTH-1:0]  out_data_r;
  logic [PACK_RATIO-1:0] out_keep_r;
  logic                  out_valid_r;

  logic                  accept_s;
  logic                  out_free_s;
  logic                  full_s;
  logic                  flush_ready_s;
  logic                  transfer_s;
  logic                  flush_drop_s;
  logic [SUM_W-1:0]      inflight_s;
  logic                  rd_en_nxt_s;
  logic [OUT_WIDTH-1:0]  acc_nxt_s;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  flush_req_nxt_s;
  logic [PACK_RATIO-1:0] keep_nxt_s;
  logic [OUT_WIDTH-1:0]  out_data_nxt_s;
  logic [PACK_RATIO-1:0] out_keep_nxt_s;
  logic                  out_valid_nxt_s;

  // Control decisions: accept, transfer, flush resolution and the read-request rule
  always_comb begin
    accept_s      = pend_r & fifo_rd_val;
    out_free_s    = ~out_valid_r | out_ready;
    full_s        = (cnt_r == CNT_FULL);
    flush_ready_s = flush_req_r & ~pend_r;
    transfer_s    = out_free_s & (full_s | (flush_ready_s & (cnt_r != CNT_ZERO)));
    flush_drop_s  = flush_ready_s & (cnt_r == CNT_ZERO);
    // Held lanes plus reads in flight must never exceed one word.
    inflight_s    = SUM_W'(cnt_r) + SUM_W'(pend_r) + SUM_W'(rd_en_r);
    rd_en_nxt_s   = (inflight_s < SUM_LIMIT) & ~flush_req_r & ~flush;
  end

  // Accumulator, lane counter and flush latch next-state
  always_comb begin
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    flush_req_nxt_s = flush_req_r;
    if (transfer_s) begin
      acc_nxt_s = {OUT_WIDTH{1'b0}};
      cnt_nxt_s = CNT_ZERO;
    end else if (accept_s) begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        acc_nxt_s[k*IN_WIDTH +: IN_WIDTH] = (cnt_r == CNT_W'(k)) ? fifo_rd_data
                                                                 : acc_r[k*IN_WIDTH +: IN_WIDTH];
      end
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end
    if (transfer_s || flush_drop_s) begin
      flush_req_nxt_s = 1'b0;
    end else if (flush) begin
      flush_req_nxt_s = 1'b1;
    end else begin
      flush_req_nxt_s = flush_req_r;
    end
  end

  // Output register next-state: load on transfer, retire on handshake, otherwise hold
  always_comb begin
    keep_nxt_s      = keep_mask(cnt_r);
    out_data_nxt_s  = out_data_r;
    out_keep_nxt_s  = out_keep_r;
    out_valid_nxt_s = out_valid_r;
    if (transfer_s) begin
      out_data_nxt_s  = mask_lanes(acc_r, keep_nxt_s);
      out_keep_nxt_s  = keep_nxt_s;
      out_valid_nxt_s = 1'b1;
    end else if (out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Packing state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= {OUT_WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      pend_r      <= 1'b0;
      flush_req_r <= 1'b0;
      rd_en_r     <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend_r      <= rd_en_r;
      flush_req_r <= flush_req_nxt_s;
      rd_en_r     <= rd_en_nxt_s;
    end
  end

  // Downstream output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_keep_r  <= {PACK_RATIO{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_nxt_s;
      out_keep_r  <= out_keep_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign out_data   = out_data_r;
  assign out_keep   = out_keep_r;
  assign out_valid  = out_valid_r;

endmodule
